// File: rtl/regfile_sb.sv
// Parametrised register file with write-back bypass, RegDst/MemToReg muxing
// and a per-register load scoreboard that drives decode hazard and stall signals.
module regfile_sb #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 4,
  parameter bit          R0_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] A_Rd1,
  input  logic [ADDR_W-1:0] A_Rd2,
  input  logic [ADDR_W-1:0] A_RdSW,
  input  logic              C_Rd1En,
  input  logic              C_Rd2En,
  input  logic              C_RdSWEn,
  output logic [DATA_W-1:0] D_Rd1,
  output logic [DATA_W-1:0] D_Rd2,
  output logic [DATA_W-1:0] D_RdSW,
  input  logic [ADDR_W-1:0] A_WriteRT,
  input  logic [ADDR_W-1:0] A_WriteRD,
  input  logic              C_RegDstWrite,
  input  logic              C_RegWrite,
  input  logic              C_MemToReg,
  input  logic [DATA_W-1:0] D_MDR_IN,
  input  logic [DATA_W-1:0] D_ALU_IN,
  input  logic              C_MarkBusy,
  input  logic [ADDR_W-1:0] A_MarkBusy,
  output logic              H_Rd1,
  output logic              H_Rd2,
  output logic              H_RdSW,
  output logic              C_Stall,
  output logic [ADDR_W:0]   N_Busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic [ADDR_W-1:0] waddr_c;
  logic [DATA_W-1:0] wdata_c;
  logic              wr_ok_c;
  logic              mark_ok_c;
  logic              cnt_inc_c;
  logic              cnt_dec_c;

  // Write port muxing; register 0 silently absorbs writes and marks when hardwired.
  always_comb begin
    waddr_c   = C_RegDstWrite ? A_WriteRD : A_WriteRT;
    wdata_c   = C_MemToReg ? D_MDR_IN : D_ALU_IN;
    wr_ok_c   = C_RegWrite & ~(R0_ZERO && (waddr_c == '0));
    mark_ok_c = C_MarkBusy & ~(R0_ZERO && (A_MarkBusy == '0));
  end

  // Net population change: a mark only counts on an idle bit, a clear only on a
  // busy bit that is not simultaneously re-marked.
  always_comb begin
    cnt_inc_c = mark_ok_c & ~busy[A_MarkBusy];
    cnt_dec_c = wr_ok_c & busy[waddr_c] & ~(mark_ok_c && (A_MarkBusy == waddr_c));
  end

  function automatic logic [DATA_W-1:0] rd_data(input logic [ADDR_W-1:0] addr);
    if (R0_ZERO && (addr == '0))
      rd_data = '0;
    else if (wr_ok_c && (addr == waddr_c))
      rd_data = wdata_c;
    else
      rd_data = mem[addr];
  endfunction

  function automatic logic hazard(input logic [ADDR_W-1:0] addr);
    hazard = busy[addr] & ~(wr_ok_c && (addr == waddr_c));
  endfunction

  // Combinational read ports with bypass and hazard detection.
  always_comb begin
    D_Rd1   = rd_data(A_Rd1);
    D_Rd2   = rd_data(A_Rd2);
    D_RdSW  = rd_data(A_RdSW);
    H_Rd1   = hazard(A_Rd1);
    H_Rd2   = hazard(A_Rd2);
    H_RdSW  = hazard(A_RdSW);
    C_Stall = (H_Rd1 & C_Rd1En) | (H_Rd2 & C_Rd2En) | (H_RdSW & C_RdSWEn);
  end

  // Register array.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (wr_ok_c) begin
      mem[waddr_c] <= wdata_c;
    end
  end

  // Scoreboard: a mark on the same register as a write-back wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      if (wr_ok_c)   busy[waddr_c]    <= 1'b0;
      if (mark_ok_c) busy[A_MarkBusy] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      N_Busy <= '0;
    end else if (cnt_inc_c && !cnt_dec_c) begin
      N_Busy <= N_Busy + CNT_W'(1);
    end else if (cnt_dec_c && !cnt_inc_c) begin
      N_Busy <= N_Busy - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb; a second instance with
// R0_ZERO=1 shares all inputs to cover the hardwired-zero register.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  A_Rd1, A_Rd2, A_RdSW, A_WriteRT, A_WriteRD, A_MarkBusy;
  logic        C_Rd1En, C_Rd2En, C_RdSWEn, C_RegDstWrite, C_RegWrite, C_MemToReg, C_MarkBusy;
  logic [15:0] D_MDR_IN, D_ALU_IN;

  logic [15:0] D_Rd1, D_Rd2, D_RdSW;
  logic        H_Rd1, H_Rd2, H_RdSW, C_Stall;
  logic [4:0]  N_Busy;

  logic [15:0] z_D_Rd1, z_D_Rd2, z_D_RdSW;
  logic        z_H_Rd1, z_H_Rd2, z_H_RdSW, z_C_Stall;
  logic [4:0]  z_N_Busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(16), .ADDR_W(4), .R0_ZERO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .A_Rd1(A_Rd1), .A_Rd2(A_Rd2), .A_RdSW(A_RdSW),
    .C_Rd1En(C_Rd1En), .C_Rd2En(C_Rd2En), .C_RdSWEn(C_RdSWEn),
    .D_Rd1(D_Rd1), .D_Rd2(D_Rd2), .D_RdSW(D_RdSW),
    .A_WriteRT(A_WriteRT), .A_WriteRD(A_WriteRD),
    .C_RegDstWrite(C_RegDstWrite), .C_RegWrite(C_RegWrite), .C_MemToReg(C_MemToReg),
    .D_MDR_IN(D_MDR_IN), .D_ALU_IN(D_ALU_IN),
    .C_MarkBusy(C_MarkBusy), .A_MarkBusy(A_MarkBusy),
    .H_Rd1(H_Rd1), .H_Rd2(H_Rd2), .H_RdSW(H_RdSW),
    .C_Stall(C_Stall), .N_Busy(N_Busy)
  );

  regfile_sb #(.DATA_W(16), .ADDR_W(4), .R0_ZERO(1'b1)) dut_z (
    .clk(clk), .rst(rst),
    .A_Rd1(A_Rd1), .A_Rd2(A_Rd2), .A_RdSW(A_RdSW),
    .C_Rd1En(C_Rd1En), .C_Rd2En(C_Rd2En), .C_RdSWEn(C_RdSWEn),
    .D_Rd1(z_D_Rd1), .D_Rd2(z_D_Rd2), .D_RdSW(z_D_RdSW),
    .A_WriteRT(A_WriteRT), .A_WriteRD(A_WriteRD),
    .C_RegDstWrite(C_RegDstWrite), .C_RegWrite(C_RegWrite), .C_MemToReg(C_MemToReg),
    .D_MDR_IN(D_MDR_IN), .D_ALU_IN(D_ALU_IN),
    .C_MarkBusy(C_MarkBusy), .A_MarkBusy(A_MarkBusy),
    .H_Rd1(z_H_Rd1), .H_Rd2(z_H_Rd2), .H_RdSW(z_H_RdSW),
    .C_Stall(z_C_Stall), .N_Busy(z_N_Busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, req);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    A_Rd1 = '0; A_Rd2 = '0; A_RdSW = '0; A_WriteRT = '0; A_WriteRD = '0; A_MarkBusy = '0;
    C_Rd1En = 0; C_Rd2En = 0; C_RdSWEn = 0; C_RegDstWrite = 0; C_RegWrite = 0;
    C_MemToReg = 0; C_MarkBusy = 0; D_MDR_IN = '0; D_ALU_IN = '0;
    #2;
    chk("rst_d_rd1", D_Rd1, 0);
    chk("rst_d_rd2", D_Rd2, 0);
    chk("rst_nbusy", N_Busy, 0);
    chk("rst_stall", C_Stall, 0);
    tick();
    rst = 1'b1;

    // RegDst=1, ALU data into r14
    A_Rd1 = 4'd14; A_Rd2 = 4'd7;
    C_RegWrite = 1; C_RegDstWrite = 1; A_WriteRD = 4'd14; A_WriteRT = 4'd7;
    C_MemToReg = 0; D_ALU_IN = 16'd777; D_MDR_IN = 16'd154;
    #1;
    chk("pre_write_rd2", D_Rd2, 0);
    chk("byp_r14_alu", D_Rd1, 777);
    tick();
    // RegDst=0, MDR data into r7
    C_RegDstWrite = 0; C_MemToReg = 1;
    #1;
    chk("byp_r7_mdr", D_Rd2, 154);
    chk("arr_r14", D_Rd1, 777);
    tick();
    C_RegWrite = 0; D_MDR_IN = 16'h5A5A;
    #1;
    chk("hold_r14", D_Rd1, 777);
    chk("hold_r7_nowrite", D_Rd2, 154);

    // Same-cycle bypass on r3
    A_Rd1 = 4'd3; A_RdSW = 4'd3;
    C_RegWrite = 1; C_RegDstWrite = 0; A_WriteRT = 4'd3; C_MemToReg = 0; D_ALU_IN = 16'h1234;
    #1;
    chk("byp_r3_rd1", D_Rd1, 16'h1234);
    chk("byp_r3_sw", D_RdSW, 16'h1234);
    tick();
    C_RegWrite = 0; D_ALU_IN = 16'hBEEF; A_Rd2 = 4'd14;
    #1;
    chk("hold_r3", D_Rd1, 16'h1234);
    chk("hold_r14_b", D_Rd2, 777);

    // Scoreboard: mark r6, hazard appears after the edge
    A_RdSW = 4'd0;
    C_MarkBusy = 1; A_MarkBusy = 4'd6; A_Rd2 = 4'd6; C_Rd2En = 1;
    #1;
    chk("mark_lat_h", H_Rd2, 0);
    tick();
    C_MarkBusy = 0;
    #1;
    chk("h_rd2_busy", H_Rd2, 1);
    chk("stall_busy", C_Stall, 1);
    chk("nbusy_1", N_Busy, 1);
    C_Rd2En = 0;
    #1;
    chk("stall_disabled", C_Stall, 0);
    C_Rd2En = 1;
    // MDR write-back to r6 clears hazard combinationally
    C_RegWrite = 1; C_MemToReg = 1; C_RegDstWrite = 0; A_WriteRT = 4'd6; D_MDR_IN = 16'h0ABC;
    #1;
    chk("wb_h_rd2", H_Rd2, 0);
    chk("wb_stall", C_Stall, 0);
    chk("wb_d_rd2", D_Rd2, 16'h0ABC);
    chk("wb_nbusy_pre", N_Busy, 1);
    tick();
    C_RegWrite = 0;
    #1;
    chk("wb_nbusy_post", N_Busy, 0);
    chk("wb_d_rd2_arr", D_Rd2, 16'h0ABC);

    // Write and mark r5 together while r5 is already busy
    C_MarkBusy = 1; A_MarkBusy = 4'd5;
    tick();
    chk("nbusy_r5", N_Busy, 1);
    A_Rd1 = 4'd5;
    C_RegWrite = 1; C_MemToReg = 0; A_WriteRT = 4'd5; D_ALU_IN = 16'h0055;
    #1;
    chk("wm5_h_comb", H_Rd1, 0);
    tick();
    C_RegWrite = 0; C_MarkBusy = 0;
    #1;
    chk("wm5_busy_kept", H_Rd1, 1);
    chk("wm5_nbusy", N_Busy, 1);
    chk("wm5_data", D_Rd1, 16'h0055);

    // Write r5 while marking r9: count unchanged
    C_RegWrite = 1; A_WriteRT = 4'd5; C_MarkBusy = 1; A_MarkBusy = 4'd9;
    tick();
    C_RegWrite = 0; C_MarkBusy = 0; A_Rd2 = 4'd9;
    #1;
    chk("w5m9_nbusy", N_Busy, 1);
    chk("w5m9_h_rd1", H_Rd1, 0);
    chk("w5m9_h_rd2", H_Rd2, 1);
    // Re-mark already-busy r9
    C_MarkBusy = 1;
    tick();
    C_MarkBusy = 0;
    #1;
    chk("remark_nbusy", N_Busy, 1);
    C_RegWrite = 1; A_WriteRT = 4'd9;
    tick();
    C_RegWrite = 0;
    #1;
    chk("clr9_nbusy", N_Busy, 0);

    // Register 0 behaviour with and without R0_ZERO
    A_Rd1 = 4'd0; A_Rd2 = 4'd0; C_Rd2En = 0;
    C_RegWrite = 1; A_WriteRT = 4'd0; D_ALU_IN = 16'hFFFF;
    #1;
    chk("r0_byp_plain", D_Rd1, 16'hFFFF);
    chk("r0_byp_zero", z_D_Rd1, 0);
    tick();
    C_RegWrite = 0;
    #1;
    chk("r0_arr_plain", D_Rd1, 16'hFFFF);
    chk("r0_arr_zero", z_D_Rd1, 0);
    C_MarkBusy = 1; A_MarkBusy = 4'd0;
    tick();
    C_MarkBusy = 0;
    #1;
    chk("r0_h_zero", z_H_Rd1, 0);
    chk("r0_nbusy_zero", z_N_Busy, 0);
    chk("r0_h_plain", H_Rd1, 1);
    chk("r0_nbusy_plain", N_Busy, 1);

    // Build up busy 2, 5, 11 with r2 = 0x00AA, then async reset
    C_RegWrite = 1; A_WriteRT = 4'd2; D_ALU_IN = 16'h00AA;
    tick();
    C_RegWrite = 0; C_MarkBusy = 1; A_MarkBusy = 4'd2;
    tick();
    A_MarkBusy = 4'd5;
    tick();
    A_MarkBusy = 4'd11;
    tick();
    C_MarkBusy = 0;
    A_Rd1 = 4'd2; A_Rd2 = 4'd5; A_RdSW = 4'd11; C_Rd1En = 1; C_Rd2En = 1; C_RdSWEn = 1;
    #1;
    chk("pre_rst_nbusy_z", z_N_Busy, 3);
    chk("pre_rst_nbusy", N_Busy, 4);
    chk("pre_rst_d_rd1", D_Rd1, 16'h00AA);
    chk("pre_rst_stall", C_Stall, 1);
    #1;
    rst = 1'b0;
    #1;
    chk("arst_nbusy", N_Busy, 0);
    chk("arst_nbusy_z", z_N_Busy, 0);
    chk("arst_h_rd1", H_Rd1, 0);
    chk("arst_h_rd2", H_Rd2, 0);
    chk("arst_h_rdsw", H_RdSW, 0);
    chk("arst_stall", C_Stall, 0);
    chk("arst_d_rd1", D_Rd1, 0);
    // Mark during reset is discarded; first edge after release is normal
    C_MarkBusy = 1; A_MarkBusy = 4'd3;
    tick();
    chk("rst_mark_drop", N_Busy, 0);
    rst = 1'b1;
    tick();
    C_MarkBusy = 0;
    #1;
    chk("post_rst_mark", N_Busy, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with write-back bypass and a per-register load scoreboard, replacing the fixed 16×16 register file in the processor datapath. It provides three combinational read ports (two operand ports and one store-data port), a single write port with RegDst and MemToReg muxing, and busy tracking for registers awaiting a load. Decode uses the hazard and stall outputs to hold issue until outstanding loads have written back.

## Interface
- DATA_W, 16, register width
- ADDR_W, 4, address width; depth = 2^ADDR_W
- R0_ZERO, 0, if 1, register 0 reads as 0 and ignores writes and marks

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-low
- A_Rd1, A_Rd2, A_RdSW  in  ADDR_W each  read addresses
- C_Rd1En, C_Rd2En, C_RdSWEn  in  1 each  read-port valid, used for stall only
- D_Rd1, D_Rd2, D_RdSW  out  DATA_W each  read data
- A_WriteRT, A_WriteRD  in  ADDR_W each  write-address candidates
- C_RegDstWrite  in  1  1 selects A_WriteRD, 0 selects A_WriteRT
- C_RegWrite  in  1  write enable
- C_MemToReg  in  1  1 selects D_MDR_IN, 0 selects D_ALU_IN
- D_MDR_IN, D_ALU_IN  in  DATA_W each  write-data candidates
- C_MarkBusy, A_MarkBusy  in  1 / ADDR_W  load issued to register A_MarkBusy
- H_Rd1, H_Rd2, H_RdSW  out  1 each  addressed register is busy
- C_Stall  out  1  OR of the enabled hazards
- N_Busy  out  ADDR_W+1  count of busy registers

## Operation
- Write address: waddr = C_RegDstWrite ? A_WriteRD : A_WriteRT.
- Write data: wdata = C_MemToReg ? D_MDR_IN : D_ALU_IN.
- Write: on the edge, when C_RegWrite=1, mem[waddr] <= wdata. When R0_ZERO=1 and waddr=0, the write is dropped.
- Reads are combinational, with a bypass. If C_RegWrite=1 and A_x == waddr (and the write is not dropped), D_x = wdata. Otherwise D_x = mem[A_x]. With R0_ZERO=1, address 0 always returns 0.
- Scoreboard, one busy bit per register:
  - Set at the edge when C_MarkBusy=1 (ignored for register 0 when R0_ZERO=1).
  - Cleared at the edge by any non-dropped write to that register.
  - Set and clear on the same register in the same cycle: set wins, so the bit stays 1.
  - Set on a register that is already busy: no change, and N_Busy does not change.
- Hazards: H_x = busy[A_x] & ~(C_RegWrite & waddr==A_x & write not dropped). A write that clears a register in the current cycle removes its hazard combinationally, consistent with the bypass.
- Stall: C_Stall = (H_Rd1&C_Rd1En) | (H_Rd2&C_Rd2En) | (H_RdSW&C_RdSWEn).
- Busy counter: N_Busy is a registered population count, updated each edge by +1, −1 or 0 according to the net busy-bit change.
  - Range is 0..2^ADDR_W (or 2^ADDR_W−1 when R0_ZERO=1).
  - It never wraps. Set and clear on different registers in the same cycle leaves it unchanged.

## Timing
- Reset (rst=0) acts immediately, without waiting for a clock edge:
  - all mem entries are 0, all busy bits are 0, N_Busy=0;
  - therefore D_*=0 (unless the bypass is active), H_*=0 and C_Stall=0.
- Reset asserted mid-operation discards any write or mark in that cycle. The first edge with rst=1 performs normal updates.
- Write latency: data is visible on reads in the same cycle through the bypass, and from the array one edge later.
- Mark latency: H_* rises on the cycle after the marking edge. N_Busy also updates at that edge.
- Load completion: the write-back cycle clears H_* combinationally. The busy bit and N_Busy update at that same edge.
- No multi-cycle state other than the busy bits and N_Busy. There are no internal waits, so throughput is one write and one mark per cycle.

## Test plan
- Reset and RegDst/MemToReg muxing:
  - Stimulus: reset, then write with C_RegDstWrite=1, A_WriteRD=14, C_MemToReg=0, D_ALU_IN=777; next write with C_RegDstWrite=0, A_WriteRT=7, C_MemToReg=1, D_MDR_IN=154.
  - Required: D_Rd1 (A=14)=777 and D_Rd2 (A=7)=154. Before the writes, all reads are 0.
- Bypass:
  - Stimulus: A_Rd1=3 and write 3←0x1234 in the same cycle.
  - Required: D_Rd1=0x1234 before the edge. With C_RegWrite=0, registers 3 and 14 hold their previous values.
- Scoreboard and stall:
  - Stimulus: mark 6, then read A_Rd2=6 with C_Rd2En=1.
  - Required: H_Rd2=1, C_Stall=1, N_Busy=1. In the MDR write-back cycle to 6, H_Rd2=0, C_Stall=0 and D_Rd2=D_MDR_IN; N_Busy=0 after the edge.
- Simultaneous events:
  - Stimulus: write 5 and mark 5 in one cycle.
  - Required: busy[5]=1 and N_Busy unchanged relative to 5 already busy. Writing 5 while marking 9 leaves N_Busy unchanged.
- R0_ZERO=1:
  - Stimulus: write 0←0xFFFF, then mark 0.
  - Required: D_Rd1 (A=0)=0, H_Rd1=0, N_Busy=0.
- Async reset mid-operation:
  - Stimulus: busy 2, 5 and 11 (N_Busy=3) and register 2 holding 0x00AA; pull rst low between clock edges.
  - Required: N_Busy=0, all H_*=0 and D_Rd1 (A=2)=0 immediately.
